morse_tx_sequencer: RTL and testbench

Transmit-side controller for the Morse hardware datapath. Accepts ASCII characters over a valid/ready handshake and encodes each one through a Morse lookup ROM. Sequences the key output through marks, element gaps, character gaps and word gaps, timed by a software-configured dot length. Sits between the Nios II char port (PIO/Avalon-facing wrapper) and the GPIO key line and LEDR timing indicators.

---
 rtl/morse_pkg.sv | 28 ++
 rtl/morse_tx_sequencer_if.sv | 26 ++
 rtl/morse_encode_rom.sv | 67 ++++++
 rtl/morse_tx_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_morse_tx_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and timing constants for the Morse datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        MARK     = 3'd2,
        GAP      = 3'd3,
        CHAR_GAP = 3'd4,
        WORD_GAP = 3'd5
    } state_t;

    // Interval lengths in dot units
    localparam logic [2:0] DOT_U  = 3'd1;
    localparam logic [2:0] DASH_U = 3'd3;
    localparam logic [2:0] GAP_U  = 3'd1;
    localparam logic [2:0] CHAR_U = 3'd3;
    localparam logic [2:0] WORD_U = 3'd7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_tx_sequencer_if
//  Description : Character valid/ready handshake into the Morse transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface morse_tx_sequencer_if;

    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_data,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_data,
        input  char_valid,
        output char_ready
    );

endinterface : morse_tx_sequencer_if
`default_nettype wire

// File: rtl/morse_encode_rom.sv
`default_nettype none
// ============================================================================
//  Module      : morse_encode_rom
//  Description : ASCII to ITU Morse lookup; element i is pat[len-1-i], 1=dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_encode_rom (
    input  wire logic [7:0] ascii,
    output logic      [2:0] len,
    output logic      [4:0] pat
);

    logic [7:0] w_fold;
    logic [7:0] w_code;

    always_comb begin
        w_fold = ascii;
        if ((ascii >= 8'h61) && (ascii <= 8'h7A)) begin
            w_fold = ascii - 8'h20;
        end
        w_code = 8'h00;
        case (w_fold)
            8'h41: w_code = {3'd2, 5'b00001};   // A .-
            8'h42: w_code = {3'd4, 5'b01000};   // B -...
            8'h43: w_code = {3'd4, 5'b01010};   // C -.-.
            8'h44: w_code = {3'd3, 5'b00100};   // D -..
            8'h45: w_code = {3'd1, 5'b00000};   // E .
            8'h46: w_code = {3'd4, 5'b00010};   // F ..-.
            8'h47: w_code = {3'd3, 5'b00110};   // G --.
            8'h48: w_code = {3'd4, 5'b00000};   // H ....
            8'h49: w_code = {3'd2, 5'b00000};   // I ..
            8'h4A: w_code = {3'd4, 5'b00111};   // J .---
            8'h4B: w_code = {3'd3, 5'b00101};   // K -.-
            8'h4C: w_code = {3'd4, 5'b00100};   // L .-..
            8'h4D: w_code = {3'd2, 5'b00011};   // M --
            8'h4E: w_code = {3'd2, 5'b00010};   // N -.
            8'h4F: w_code = {3'd3, 5'b00111};   // O ---
            8'h50: w_code = {3'd4, 5'b00110};   // P .--.
            8'h51: w_code = {3'd4, 5'b01101};   // Q --.-
            8'h52: w_code = {3'd3, 5'b00010};   // R .-.
            8'h53: w_code = {3'd3, 5'b00000};   // S ...
            8'h54: w_code = {3'd1, 5'b00001};   // T -
            8'h55: w_code = {3'd3, 5'b00001};   // U ..-
            8'h56: w_code = {3'd4, 5'b00001};   // V ...-
            8'h57: w_code = {3'd3, 5'b00011};   // W .--
            8'h58: w_code = {3'd4, 5'b01001};   // X -..-
            8'h59: w_code = {3'd4, 5'b01011};   // Y -.--
            8'h5A: w_code = {3'd4, 5'b01100};   // Z --..
            8'h30: w_code = {3'd5, 5'b11111};
            8'h31: w_code = {3'd5, 5'b01111};
            8'h32: w_code = {3'd5, 5'b00111};
            8'h33: w_code = {3'd5, 5'b00011};
            8'h34: w_code = {3'd5, 5'b00001};
            8'h35: w_code = {3'd5, 5'b00000};
            8'h36: w_code = {3'd5, 5'b10000};
            8'h37: w_code = {3'd5, 5'b11000};
            8'h38: w_code = {3'd5, 5'b11100};
            8'h39: w_code = {3'd5, 5'b11110};
            default: w_code = 8'h00;
        endcase
    end

    assign len = w_code[7:5];
    assign pat = w_code[4:0];

endmodule : morse_encode_rom
`default_nettype wire

// File: rtl/morse_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_tx_sequencer
//  Description : Sequences key marks and gaps for one ASCII char at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_tx_sequencer
    import morse_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int PRE_W    = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    morse_tx_sequencer_if.slave char_if,
    input  wire logic [7:0]     dot_units,
    input  wire logic           mode,
    output logic                key_out,
    output logic                dot_time,
    output logic                wait_time,
    output logic                busy,
    output logic                err_unsupported
);

    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_char;
    logic [7:0]       r_dot;
    logic [2:0]       r_idx;
    logic [2:0]       w_next_idx;
    logic [PRE_W-1:0] r_pre;
    logic [10:0]      r_cnt;

    logic             w_ready;
    logic             w_accept;
    logic [7:0]       w_rom_char;
    logic [2:0]       w_len;
    logic [4:0]       w_pat;
    logic [7:0]       w_pat8;
    logic [2:0]       w_cur_sel;
    logic [2:0]       w_nxt_sel;
    logic             w_cur_dash;
    logic             w_nxt_dash;
    logic             w_more;
    logic [2:0]       w_units;
    logic [10:0]      w_target;
    logic             w_tick;
    logic             w_done;
    logic             w_err;

    assign w_ready            = mode & (r_state == IDLE);
    assign char_if.char_ready = w_ready;
    assign w_accept           = char_if.char_valid & w_ready;

    // In IDLE the ROM looks at the incoming char so the error pulse lines up with LOAD
    assign w_rom_char = (r_state == IDLE) ? char_if.char_data : r_char;

    morse_encode_rom u_rom (
        .ascii (w_rom_char),
        .len   (w_len),
        .pat   (w_pat)
    );

    assign w_pat8     = {3'b000, w_pat};
    assign w_cur_sel  = w_len - 3'd1 - r_idx;
    assign w_nxt_sel  = w_len - 3'd1 - w_next_idx;
    assign w_cur_dash = w_pat8[w_cur_sel];
    assign w_nxt_dash = w_pat8[w_nxt_sel];
    assign w_more     = ({1'b0, r_idx} + 4'd1) < {1'b0, w_len};

    always_comb begin
        w_units = DOT_U;
        case (r_state)
            MARK:     w_units = w_cur_dash ? DASH_U : DOT_U;
            GAP:      w_units = GAP_U;
            CHAR_GAP: w_units = CHAR_U;
            WORD_GAP: w_units = WORD_U;
            default:  w_units = DOT_U;
        endcase
    end

    assign w_target = 11'(w_units) * 11'(r_dot);
    assign w_tick   = (r_pre == c_pre_last);
    assign w_done   = w_tick && (r_cnt == (w_target - 11'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        w_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = LOAD;
                    w_err  = (char_if.char_data != ASCII_SPACE) && (w_len == 3'd0);
                end
            end
            LOAD: begin
                w_next_idx = 3'd0;
                if (r_char == ASCII_SPACE) begin
                    w_next = WORD_GAP;
                end else if (w_len == 3'd0) begin
                    w_next = IDLE;
                end else begin
                    w_next = MARK;
                end
            end
            MARK: begin
                if (w_done) begin
                    w_next = w_more ? GAP : CHAR_GAP;
                end
            end
            GAP: begin
                if (w_done) begin
                    w_next     = MARK;
                    w_next_idx = r_idx + 3'd1;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Abort discards the character; nothing resumes later
        if (!mode && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_char <= 8'h00;
            r_dot  <= 8'h00;
            r_idx  <= 3'd0;
            r_pre  <= '0;
            r_cnt  <= 11'd0;
        end else begin
            if (w_accept) begin
                r_char <= char_if.char_data;
                r_dot  <= (dot_units == 8'h00) ? 8'h01 : dot_units;
            end
            r_idx <= w_next_idx;
            // Restarting on every state entry makes each interval an exact multiple
            if ((w_next != r_state) || (r_state == IDLE) || (r_state == LOAD)) begin
                r_pre <= '0;
                r_cnt <= 11'd0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_cnt <= r_cnt + 11'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out         <= 1'b0;
            dot_time        <= 1'b0;
            wait_time       <= 1'b0;
            busy            <= 1'b0;
            err_unsupported <= 1'b0;
        end else begin
            key_out         <= (w_next == MARK);
            dot_time        <= (w_next == MARK) && !w_nxt_dash;
            wait_time       <= (w_next == CHAR_GAP) || (w_next == WORD_GAP);
            busy            <= (w_next != IDLE);
            err_unsupported <= w_err;
        end
    end

endmodule : morse_tx_sequencer
`default_nettype wire

// File: tb/tb_morse_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_tx_sequencer
//  Description : Self-checking bench for morse_tx_sequencer (PRESCALE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_tx_sequencer;

    localparam int PRESCALE = 4;
    localparam int PRE_W    = 4;

    logic       clk;
    logic       reset;
    logic [7:0] dot_units;
    logic       mode;
    logic       key_out;
    logic       dot_time;
    logic       wait_time;
    logic       busy;
    logic       err_unsupported;

    int errors = 0;
    int checks = 0;

    morse_tx_sequencer_if char_if ();

    morse_tx_sequencer #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .char_if         (char_if.slave),
        .dot_units       (dot_units),
        .mode            (mode),
        .key_out         (key_out),
        .dot_time        (dot_time),
        .wait_time       (wait_time),
        .busy            (busy),
        .err_unsupported (err_unsupported)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic key;
        logic dot;
        logic wt;
        logic busy;
        logic err;
        logic rdy;
    } cyc_t;

    cyc_t exp_q[$];

    typedef struct {
        logic [7:0] c;
        int         du;
        int         key_n;
        int         dot_n;
        int         wait_n;
        int         busy_n;
        int         err_n;
        int         key_first;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Morse as dot/dash text, looked up independently of the DUT's table
    function automatic string ref_code(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if ((c >= 8'h61) && (c <= 8'h7a)) u = c - 8'h20;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    function automatic void push(input logic k, input logic d, input logic w,
                                 input logic b, input logic e, input logic r, input int n);
        cyc_t x;
        x = {k, d, w, b, e, r};
        repeat (n) exp_q.push_back(x);
    endfunction

    // Expected per-cycle waveform from the cycle after accept up to the first idle cycle
    function automatic void build_model(input logic [7:0] c, input int du);
        string code;
        int    u;
        bit    dash;
        code = ref_code(c);
        u    = ((du == 0) ? 1 : du) * PRESCALE;
        exp_q.delete();
        push(0, 0, 0, 1, (c != 8'h20) && (code.len() == 0), 0, 1);
        if (c == 8'h20) begin
            push(0, 0, 1, 1, 0, 0, 7 * u);
        end else if (code.len() > 0) begin
            for (int i = 0; i < code.len(); i++) begin
                dash = (code[i] == "-");
                push(1, !dash, 0, 1, 0, 0, (dash ? 3 : 1) * u);
                if (i < code.len() - 1) push(0, 0, 0, 1, 0, 0, u);
            end
            push(0, 0, 1, 1, 0, 0, 3 * u);
        end
        push(0, 0, 0, 0, 0, 1, 1);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle
    task automatic run_char(input logic [7:0] c, input int du);
        cyc_t  got;
        int    bad;
        int    at;
        cyc_t  exp_at;
        cyc_t  got_at;
        build_model(c, du);
        char_if.char_data  = c;
        char_if.char_valid = 1'b1;
        dot_units          = 8'(du);
        @(posedge clk);
        #1;
        char_if.char_valid = 1'b0;
        char_if.char_data  = 8'($urandom);
        bad    = 0;
        at     = 0;
        exp_at = '0;
        got_at = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            dot_units = 8'($urandom);
            @(negedge clk);
            got = {key_out, dot_time, wait_time, busy, err_unsupported, char_if.char_ready};
            if ((got != exp_q[i]) && (bad == 0)) begin
                bad    = 1;
                at     = i + 1;
                exp_at = exp_q[i];
                got_at = got;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rand_char 0x%02h du=%0d cycle %0d: got key/dot/wait/busy/err/rdy=%06b expected %06b",
                     c, du, at, got_at, exp_at);
        end
    endtask

    // Counts output activity for one character; bounded so a stuck DUT cannot hang
    task automatic measure(input vec_t v);
        int key_n, dot_n, wait_n, busy_n, err_n, key_first, n;
        bit done;
        key_n = 0; dot_n = 0; wait_n = 0; busy_n = 0; err_n = 0; key_first = 0;
        done  = 0;
        char_if.char_data  = v.c;
        char_if.char_valid = 1'b1;
        dot_units          = 8'(v.du);
        @(posedge clk);
        #1;
        char_if.char_valid = 1'b0;
        n = 0;
        while (!done && (n < 2000)) begin
            dot_units = 8'($urandom);
            @(negedge clk);
            n++;
            if (char_if.char_ready) begin
                done = 1;
            end else begin
                if (key_out) key_n++;
                if (key_out && (key_first == 0)) key_first = n;
                if (dot_time) dot_n++;
                if (wait_time) wait_n++;
                if (busy) busy_n++;
                if (err_unsupported) err_n++;
            end
        end
        chk($sformatf("ready_return_0x%02h", v.c), int'(done), 1);
        chk($sformatf("key_cycles_0x%02h", v.c), key_n, v.key_n);
        chk($sformatf("dot_cycles_0x%02h", v.c), dot_n, v.dot_n);
        chk($sformatf("wait_cycles_0x%02h", v.c), wait_n, v.wait_n);
        chk($sformatf("busy_cycles_0x%02h", v.c), busy_n, v.busy_n);
        chk($sformatf("err_pulses_0x%02h", v.c), err_n, v.err_n);
        chk($sformatf("key_first_0x%02h", v.c), key_first, v.key_first);
    endtask

    vec_t  vecs[9];
    string pool;
    int    n;

    initial begin
        // c, du, key, dot, wait, busy, err, key_first (cycle index after accept)
        vecs[0] = '{8'h45, 2,  8,  8, 24, 33, 0, 2};   // E
        vecs[1] = '{8'h41, 2, 32,  8, 24, 65, 0, 2};   // A
        vecs[2] = '{8'h20, 2,  0,  0, 56, 57, 0, 0};   // space
        vecs[3] = '{8'h23, 2,  0,  0,  0,  1, 1, 0};   // '#'
        vecs[4] = '{8'h65, 2,  8,  8, 24, 33, 0, 2};   // e
        vecs[5] = '{8'h54, 0, 12,  0, 12, 25, 0, 2};   // T, dot_units 0 -> 1
        vecs[6] = '{8'h30, 1, 60,  0, 12, 89, 0, 2};   // 0
        vecs[7] = '{8'h53, 1, 12, 12, 12, 33, 0, 2};   // S
        vecs[8] = '{8'h7a, 1, 32,  8, 12, 57, 0, 2};   // z

        reset              = 1'b1;
        mode               = 1'b1;
        dot_units          = 8'd2;
        char_if.char_data  = 8'h00;
        char_if.char_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_key", int'(key_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wait", int'(wait_time), 0);
        chk("reset_err", int'(err_unsupported), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(char_if.char_ready), 1);

        foreach (vecs[i]) measure(vecs[i]);

        // Asynchronous reset in the middle of the first dash of 'O'
        char_if.char_data  = "O";
        char_if.char_valid = 1'b1;
        dot_units          = 8'd1;
        @(posedge clk);
        #1;
        char_if.char_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("O_key_before_reset", int'(key_out), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_key", int'(key_out), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_dot", int'(dot_time), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_reset_ready", int'(char_if.char_ready), 1);

        // Drop mode in the middle of a 'T' mark
        @(negedge clk);
        char_if.char_data  = "T";
        char_if.char_valid = 1'b1;
        dot_units          = 8'd2;
        @(posedge clk);
        #1;
        char_if.char_valid = 1'b0;
        repeat (5) @(negedge clk);
        mode = 1'b0;
        #1;
        chk("mode0_key_held_until_edge", int'(key_out), 1);
        chk("mode0_ready", int'(char_if.char_ready), 0);
        @(posedge clk);
        #1;
        chk("mode0_key", int'(key_out), 0);
        chk("mode0_busy", int'(busy), 0);
        chk("mode0_wait", int'(wait_time), 0);
        repeat (3) @(negedge clk);
        chk("mode0_ready_idle", int'(char_if.char_ready), 0);
        chk("mode0_no_resume", int'(key_out), 0);
        mode = 1'b1;
        #1;
        chk("mode1_ready", int'(char_if.char_ready), 1);
        @(negedge clk);

        // Random back-to-back traffic against the reference waveform model
        pool = "ETAOINSHRDLUabcxyz0123456789 #!?.";
        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(0, pool.len()));
            if (n == pool.len()) begin
                run_char(8'($urandom), int'($urandom_range(0, 3)));
            end else begin
                run_char(pool[n], int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_morse_tx_sequencer
`default_nettype wire
